// File: rtl/riscv_pkg.sv
// Shared constants and types for the integer register file.
// Imported by the delay line, the interface and the regfile top.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = $clog2(NREG);
  localparam int WB_DELAY   = 3;

  typedef logic [4:0]      reg_addr_t;
  typedef logic [XLEN-1:0] xlen_t;

endpackage

// File: rtl/riscv_regfile_if.sv
// Register file bus: decode-side reads, decode-time destination,
// and write-back data/enable.
interface riscv_regfile_if;
  import riscv_pkg::*;

  reg_addr_t AddrA_i;
  reg_addr_t AddrB_i;
  reg_addr_t AddrD_i;
  xlen_t     DataD_i;
  logic      RegWEn_i;
  xlen_t     DataA_o;
  xlen_t     DataB_o;

  modport master (
    output AddrA_i,
    output AddrB_i,
    output AddrD_i,
    output DataD_i,
    output RegWEn_i,
    input  DataA_o,
    input  DataB_o
  );

  modport slave (
    input  AddrA_i,
    input  AddrB_i,
    input  AddrD_i,
    input  DataD_i,
    input  RegWEn_i,
    output DataA_o,
    output DataB_o
  );

endinterface

// File: rtl/riscv_addr_delay.sv
// DEPTH-stage shift register with synchronous reset.
// Carries destination addresses from decode to write-back.
module riscv_addr_delay #(
  parameter int DEPTH = 3,
  parameter int W     = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++)
        stage[k] <= '0;
    end else begin
      stage[0] <= d;
      for (int k = 1; k < DEPTH; k++)
        stage[k] <= stage[k-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/riscv_regfile.sv
// 32 x XLEN integer register file, two combinational reads,
// one write whose address is delayed to meet write-back data.
module riscv_regfile
  import riscv_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  riscv_regfile_if.slave rf
);

  reg_addr_t waddr;
  xlen_t     regs [NREG];

  riscv_addr_delay #(
    .DEPTH (WB_DELAY),
    .W     ($bits(reg_addr_t))
  ) u_addr_delay (
    .clk (clk_i),
    .rst (rst_i),
    .d   (rf.AddrD_i),
    .q   (waddr)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (rf.RegWEn_i && waddr != '0) begin
      regs[waddr] <= rf.DataD_i;
    end
  end

  // x0 is forced on the read side so its storage never matters
  assign rf.DataA_o = (rf.AddrA_i == '0) ? '0 : regs[rf.AddrA_i];
  assign rf.DataB_o = (rf.AddrB_i == '0) ? '0 : regs[rf.AddrB_i];

endmodule

// File: tb/tb_riscv_regfile.sv
// Directed and random stimulus for riscv_regfile against
// a queue-based reference model.
module tb_riscv_regfile;
  import riscv_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  logic [31:0] mdl [32];
  int          hist [$];

  riscv_regfile_if rf_if ();

  riscv_regfile dut (
    .clk_i (clk),
    .rst_i (rst),
    .rf    (rf_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mread(input int a);
    return (a == 0) ? 32'h0 : mdl[a];
  endfunction

  task automatic mupdate(input logic r, input int rd,
                         input logic [31:0] wd, input logic we);
    int wa;
    if (r) begin
      foreach (mdl[i]) mdl[i] = '0;
      hist = '{0, 0, 0};
    end else begin
      wa = hist.pop_front();
      if (we && wa != 0) mdl[wa] = wd;
      hist.push_back(rd);
    end
  endtask

  // one clock: drive at negedge, check reads, model the edge
  task automatic cycle(input string tag, input logic r,
                       input int ra, input int rb, input int rd,
                       input logic [31:0] wd, input logic we);
    @(negedge clk);
    rst            = r;
    rf_if.AddrA_i  = reg_addr_t'(ra);
    rf_if.AddrB_i  = reg_addr_t'(rb);
    rf_if.AddrD_i  = reg_addr_t'(rd);
    rf_if.DataD_i  = wd;
    rf_if.RegWEn_i = we;
    #1;
    chk({tag, "_a"}, rf_if.DataA_o, mread(ra));
    chk({tag, "_b"}, rf_if.DataB_o, mread(rb));
    @(posedge clk);
    mupdate(r, rd, wd, we);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    foreach (mdl[i]) mdl[i] = '0;
    hist = '{0, 0, 0};
    rst            = 1'b1;
    rf_if.AddrA_i  = '0;
    rf_if.AddrB_i  = '0;
    rf_if.AddrD_i  = '0;
    rf_if.DataD_i  = '0;
    rf_if.RegWEn_i = 1'b0;

    // reset flush, enable held during/after reset goes to x0
    cycle("rst0", 1, 0, 0, 7, 32'h1111, 1);
    cycle("rst1", 1, 0, 0, 9, 32'h2222, 1);
    cycle("flush0", 0, 0, 1, 0, 32'h3333, 1);
    cycle("flush1", 0, 0, 1, 0, 0, 0);
    cycle("flush2", 0, 0, 1, 0, 0, 0);
    for (int a = 0; a < 32; a += 2)
      cycle("clr", 0, a, a + 1, 0, 0, 0);

    // delayed write to x2, then x8 in its own slot
    cycle("d_n0", 0, 0, 0, 2, 0, 0);
    cycle("d_n1", 0, 0, 0, 3, 0, 0);
    cycle("d_n2", 0, 0, 0, 8, 0, 0);
    cycle("d_n3", 0, 2, 0, 0, 32'h16, 1);
    cycle("d_n4", 0, 2, 3, 0, 0, 0);
    cycle("d_n5", 0, 2, 8, 0, 32'h18, 1);
    cycle("d_n6", 0, 2, 8, 0, 0, 0);
    chk("x2_val", rf_if.DataA_o, 32'h16);
    chk("x8_val", rf_if.DataB_o, 32'h18);
    cycle("same", 0, 2, 2, 0, 0, 0);
    chk("same_b", rf_if.DataB_o, 32'h16);

    // no bypass on x5
    cycle("nb0", 0, 5, 0, 5, 0, 0);
    cycle("nb1", 0, 5, 0, 0, 0, 0);
    cycle("nb2", 0, 5, 0, 0, 0, 0);
    cycle("nb3", 0, 5, 5, 0, 32'h12, 1);
    chk("nb_old", rf_if.DataA_o, 32'h0);
    cycle("nb4", 0, 5, 5, 0, 0, 0);
    chk("nb_new", rf_if.DataA_o, 32'h12);

    // x0 write ignored
    cycle("z0", 0, 0, 0, 0, 0, 0);
    cycle("z1", 0, 0, 0, 0, 0, 0);
    cycle("z2", 0, 0, 0, 0, 0, 0);
    cycle("z3", 0, 0, 0, 0, 32'hFFFFFFFF, 1);
    cycle("z4", 0, 0, 0, 0, 0, 0);
    chk("x0_zero", rf_if.DataA_o, 32'h0);

    // mid-flight reset drops queued x9/x10 writes
    cycle("mr0", 0, 2, 8, 9, 0, 0);
    cycle("mr1", 0, 2, 8, 10, 0, 0);
    cycle("mr2", 1, 2, 8, 0, 32'hAA, 1);
    cycle("mr3", 0, 2, 8, 0, 32'hBB, 1);
    chk("mr_x2", rf_if.DataA_o, 32'h0);
    chk("mr_x8", rf_if.DataB_o, 32'h0);
    cycle("mr4", 0, 9, 10, 0, 32'hCC, 1);
    cycle("mr5", 0, 9, 10, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      automatic logic r  = ($urandom_range(0, 59) == 0);
      automatic int   ra = $urandom_range(0, 31);
      automatic int   rb = ($urandom_range(0, 3) == 0) ?
                           ra : $urandom_range(0, 31);
      automatic int   rd = ($urandom_range(0, 7) == 0) ?
                           0 : $urandom_range(0, 31);
      automatic logic we = ($urandom_range(0, 3) != 0);
      cycle("rnd", r, ra, rb, rd, $urandom, we);
    end

    for (int a = 0; a < 32; a += 2)
      cycle("final", 0, a, a + 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
